operand_stage_buffer: RTL and testbench

OPERAND_STAGE_BUFFER -- requirements
Module: operand_stage_buffer

---
 rtl/operand_stage_buffer.sv | 95 +++++++++
 tb/tb_operand_stage_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/operand_stage_buffer.sv
`default_nettype none
// ============================================================================
// Module      : operand_stage_buffer
// Description : 2-entry in-order operand FIFO ({sel, a, b}) feeding a 2:1 mux.
//               Optional synchronous flush port enabled by OPERAND_FLUSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_stage_buffer #(
    parameter int A_WIDTH = 32,
    parameter int B_WIDTH = 192
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef OPERAND_FLUSH_EN
    input  logic               flush,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] in_a,
    input  logic [B_WIDTH-1:0] in_b,
    input  logic               in_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_WIDTH-1:0] out_a,
    output logic [B_WIDTH-1:0] out_b,
    output logic               out_sel,
    output logic [1:0]         count
);

    localparam int E_WIDTH = 1 + A_WIDTH + B_WIDTH;

    logic [E_WIDTH-1:0] mem_q [0:1];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               push_w, pop_w, wr_en_w, head_idx_w;

    always_comb begin
        in_ready  = (count_q != 2'd2);
        out_valid = (count_q != 2'd0);
        push_w    = in_valid && in_ready;
        pop_w     = out_valid && out_ready;
        wr_en_w   = push_w;
        wr_ptr_d  = push_w ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d  = pop_w  ? ~rd_ptr_q : rd_ptr_q;
        count_d   = count_q;
        case ({push_w, pop_w})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
`ifdef OPERAND_FLUSH_EN
        // Park both pointers one past the current head so the output mux
        // (which shows the slot behind rd_ptr when empty) keeps presenting it.
        if (flush) begin
            wr_en_w = 1'b0;
            count_d = 2'd0;
            if (count_q != 2'd0) begin
                rd_ptr_d = ~rd_ptr_q;
                wr_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
                wr_ptr_d = wr_ptr_q;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (wr_en_w) begin
                mem_q[wr_ptr_q] <= {in_sel, in_a, in_b};
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // When empty, the slot just behind rd_ptr holds the last popped entry.
    always_comb begin
        head_idx_w = out_valid ? rd_ptr_q : ~rd_ptr_q;
        {out_sel, out_a, out_b} = mem_q[head_idx_w];
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_stage_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_stage_buffer
// Description : Scoreboard bench for operand_stage_buffer with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_stage_buffer;

    localparam int AW = 32;
    localparam int BW = 192;
    localparam int EW = 1 + AW + BW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_sel;
    logic [AW-1:0] in_a;
    logic [BW-1:0] in_b;
    logic          out_valid, out_ready, out_sel;
    logic [AW-1:0] out_a;
    logic [BW-1:0] out_b;
    logic [1:0]    count;
`ifdef OPERAND_FLUSH_EN
    logic          flush = 1'b0;
`endif

    int vectors    = 0;
    int miscompares = 0;
    logic [EW-1:0] exp_q [$];

    always #5 clk = ~clk;

    operand_stage_buffer #(.A_WIDTH(AW), .B_WIDTH(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef OPERAND_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_sel   (out_sel),
        .count     (count)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand set; the expected entry is queued once acceptance is certain.
    task automatic send(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic s);
        int n;
        in_valid = 1'b1; in_a = a; in_b = b; in_sel = s;
        n = 0;
        while (!in_ready && n < 20) begin
            cycle();
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 (a=%0h)", a);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back({s, a, b});
        cycle();
        in_valid = 1'b0;
    endtask

    // Monitor: every accepted output beat is compared with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL head_unexpected: got %0h expected none", out_a);
            end else begin
                chk("head_entry", {31'd0, out_sel, out_a, out_b}, {31'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_a = 32'hDEADBEEF; in_b = {6{32'h12345678}}; in_sel = 1'b1;
        #3;
        chk("rst_count",     count,     0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_a",     out_a,     0);
        chk("rst_out_b",     out_b,     0);
        chk("rst_out_sel",   out_sel,   0);
        cycle();
        rst_n = 1'b1; in_valid = 1'b0;
        cycle();

        // Single pass
        out_ready = 1'b1;
        send(32'hF0F0F0F0, {6{32'h80000001}}, 1'b0);
        chk("pass_out_valid", out_valid, 1);
        chk("pass_out_a",     out_a,     32'hF0F0F0F0);
        chk("pass_out_b",     out_b,     {6{32'h80000001}});
        cycle();
        chk("pass_count_0",   count,     0);
        chk("pass_valid_0",   out_valid, 0);
        chk("pass_held_a",    out_a,     32'hF0F0F0F0);

        // Backpressure
        out_ready = 1'b0;
        send(32'd1, {6{32'h11111111}}, 1'b1);
        send(32'd2, {6{32'h22222222}}, 1'b0);
        in_valid = 1'b1; in_a = 32'd3; in_b = {6{32'h33333333}}; in_sel = 1'b1;
        chk("bp_count_2",  count,    2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_a",    out_a,    1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_hold_a",     out_a,    1);
            chk("bp_hold_ready", in_ready, 0);
        end

        // Drain order 1,2,3
        out_ready = 1'b1;
        send(32'd3, {6{32'h33333333}}, 1'b1);
        chk("drain_count_1", count,     1);
        chk("drain_valid",   out_valid, 1);
        chk("drain_head_3",  out_a,     3);
        cycle();
        chk("drain_count_0", count,     0);

        // Simultaneous push/pop at count=1
        out_ready = 1'b0;
        send(32'd10, {6{32'hA5A5A5A5}}, 1'b0);
        chk("pp_count_1", count, 1);
        out_ready = 1'b1;
        send(32'hFFFFFFFF, {BW{1'b1}}, 1'b1);
        chk("pp_count_keep", count, 1);
        chk("pp_new_head",   out_a, 32'hFFFFFFFF);
        cycle();
        chk("pp_count_0", count, 0);

        // Streaming burst with out_ready held high
        for (int i = 0; i < 4; i++) begin
            send(32'h1000 + i, {6{32'h01010101 * (i + 1)}}, i[0]);
            chk("burst_count", count, 1);
        end
        cycle();
        chk("burst_count_0", count, 0);

        // Reset mid-transfer
        out_ready = 1'b0;
        send(32'h77, {6{32'h77777777}}, 1'b1);
        send(32'h88, {6{32'h88888888}}, 1'b0);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_count", count, 0);
        chk("mid_rst_out_a", out_a, 0);
        cycle();
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(32'h55, {6{32'h55555555}}, 1'b0);
        chk("mid_rst_first", out_a, 32'h55);
        cycle();

`ifdef OPERAND_FLUSH_EN
        out_ready = 1'b0;
        send(32'hA1, {6{32'hA1A1A1A1}}, 1'b1);
        send(32'hA2, {6{32'hA2A2A2A2}}, 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_a = 32'hBAD; in_b = '0; in_sel = 1'b0;
        exp_q.delete();
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count",  count,     0);
        chk("flush_valid",  out_valid, 0);
        chk("flush_held_a", out_a,     32'hA1);
        cycle();
        chk("flush_no_push", count, 0);
`endif

        cycle();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
